// File: rtl/noc_rr_out_port_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// noc_rr_out_port_if : request channels, serial node link and queue status
// Revision 1.0
// ---------------------------------------------------------------------------
interface noc_rr_out_port_if #(
  parameter int N_IN  = 4,
  parameter int DEPTH = 4,
  parameter int PKT_W = 32
);
  logic [N_IN-1:0]            req_valid;
  logic [N_IN*PKT_W-1:0]      req_pkt;
  logic [N_IN-1:0]            req_ready;
  logic                       free_out;
  logic                       put_out;
  logic [7:0]                 payload_out;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  logic                       full;

  modport master (
    output req_valid, req_pkt, free_out,
    input  req_ready, put_out, payload_out, occupancy, full
  );

  modport slave (
    input  req_valid, req_pkt, free_out,
    output req_ready, put_out, payload_out, occupancy, full
  );
endinterface
`default_nettype wire

// File: rtl/noc_rr_out_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// noc_rr_out_port : round-robin arbiter, packet FIFO and MSB-first byte serialiser
// Revision 1.0
// ---------------------------------------------------------------------------
module noc_rr_out_port #(
  parameter int N_IN  = 4,
  parameter int DEPTH = 4,
  parameter int PKT_W = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_b,
  noc_rr_out_port_if.slave   port_if
);
  localparam int NBYTES = PKT_W / 8;
  localparam int PW     = $clog2(N_IN);
  localparam int AW     = $clog2(DEPTH);
  localparam int OW     = $clog2(DEPTH + 1);
  localparam int CW     = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [OW-1:0] OCC_FULL  = OW'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PKT_W-1:0]   shift_q, shift_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]      occ_q, occ_d;
  logic [PKT_W-1:0]   mem_q [DEPTH];

  logic               full, empty;
  logic               grant_found;
  logic [PW-1:0]      grant_idx;
  logic [PW-1:0]      cand;
  logic [N_IN-1:0]    grant_vec;
  logic [PKT_W-1:0]   sel_pkt;
  logic               push, pop;

  assign full  = (occ_q == OCC_FULL);
  assign empty = (occ_q == '0);

  // Search starts one past the last winner so every waiting channel is served in turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    grant_vec   = '0;
    for (int k = 1; k <= N_IN; k++) begin
      cand = PW'((int'(ptr_q) + k) % N_IN);
      if (!grant_found && port_if.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    if (full || rst_b) begin
      grant_found = 1'b0;
    end
    if (grant_found) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (PW'(i) == grant_idx) begin
        sel_pkt = port_if.req_pkt[i*PKT_W +: PKT_W];
      end
    end
  end

  assign push  = grant_found;
  assign ptr_d = push ? grant_idx : ptr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && port_if.free_out) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        shift_d = {shift_q[PKT_W-9:0], 8'h00};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BYTE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d    = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      ptr_q    <= PW'(N_IN - 1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sel_pkt;
    end
  end

  assign port_if.req_ready   = grant_vec;
  assign port_if.put_out     = (state_q == SEND);
  assign port_if.payload_out = (state_q == SEND) ? shift_q[PKT_W-1 -: 8] : 8'h00;
  assign port_if.occupancy   = occ_q;
  assign port_if.full        = full;
endmodule
`default_nettype wire

// File: tb/tb_noc_rr_out_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_noc_rr_out_port : directed vector table plus reset, backpressure and abort sequences
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_noc_rr_out_port;
  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  noc_rr_out_port_if #(.N_IN(4), .DEPTH(4), .PKT_W(32)) bus ();

  noc_rr_out_port #(.N_IN(4), .DEPTH(4), .PKT_W(32)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .port_if (bus.slave)
  );

  typedef struct {
    logic [3:0] valid;
    logic       free;
    logic [3:0] ready;
    logic       put;
    logic [7:0] pay;
    logic [2:0] occ;
    logic       full;
  } vec_t;

  vec_t tbl [30];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] t4_pkt(input int k);
    logic [31:0] p;
    p = 32'h11223344 + 32'h01010101 * k;
    return p;
  endfunction

  logic [7:0] bytes_q [$];
  logic       accepted5;
  logic       put_seen;

  initial begin
    // Rows are cycles; outputs are sampled 1ns after the falling edge.
    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd1, 1'b0};
    tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA1, 3'd0, 1'b0};
    tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'hB2, 3'd0, 1'b0};
    tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'hC3, 3'd0, 1'b0};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'hD4, 3'd0, 1'b0};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[7]  = '{4'b1111, 1'b0, 4'b1000, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0001, 1'b0, 8'h00, 3'd1, 1'b0};
    tbl[9]  = '{4'b1111, 1'b0, 4'b0010, 1'b0, 8'h00, 3'd2, 1'b0};
    tbl[10] = '{4'b1111, 1'b0, 4'b0100, 1'b0, 8'h00, 3'd3, 1'b0};
    tbl[11] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd4, 1'b1};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd4, 1'b1};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hE1, 3'd3, 1'b0};
    tbl[14] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hE2, 3'd3, 1'b0};
    tbl[15] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hE3, 3'd3, 1'b0};
    tbl[16] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hE4, 3'd3, 1'b0};
    tbl[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd3, 1'b0};
    tbl[18] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd3, 1'b0};
    tbl[19] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd3, 1'b0};
    tbl[20] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'h10, 3'd2, 1'b0};
    tbl[21] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'h20, 3'd2, 1'b0};
    tbl[22] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'h30, 3'd2, 1'b0};
    tbl[23] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'h40, 3'd2, 1'b0};
    tbl[24] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd2, 1'b0};
    tbl[25] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 8'h51, 3'd1, 1'b0};
    tbl[26] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 8'h52, 3'd2, 1'b0};
    tbl[27] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h53, 3'd3, 1'b0};
    tbl[28] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h54, 3'd3, 1'b0};
    tbl[29] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd3, 1'b0};

    // Reset held with every channel requesting.
    bus.req_valid = 4'b1111;
    bus.req_pkt   = {32'hE1E2E3E4, 32'hA1B2C3D4, 32'h51525354, 32'h10203040};
    bus.free_out  = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", {bus.req_ready, bus.put_out, bus.payload_out, bus.occupancy, bus.full},
        {4'b0000, 1'b0, 8'h00, 3'd0, 1'b0});
    @(negedge clk);
    bus.req_valid = 4'b0000;
    rst_b = 1'b0;

    for (int v = 0; v < 30; v++) begin
      @(negedge clk);
      bus.req_valid = tbl[v].valid;
      bus.free_out  = tbl[v].free;
      #1;
      chk($sformatf("vec%0d", v),
          {bus.req_ready, bus.put_out, bus.payload_out, bus.occupancy, bus.full},
          {tbl[v].ready, tbl[v].put, tbl[v].pay, tbl[v].occ, tbl[v].full});
    end

    // Abort mid-packet: two bytes out, then asynchronous reset between edges.
    @(negedge clk);
    bus.req_valid = 4'b0000;
    bus.free_out  = 1'b0;
    #1;
    chk("abort_byte1", {bus.put_out, bus.payload_out}, {1'b1, 8'hA1});
    @(negedge clk);
    #1;
    chk("abort_byte2", {bus.put_out, bus.payload_out}, {1'b1, 8'hB2});
    #1 rst_b = 1'b1;
    #1;
    chk("abort_async", {bus.put_out, bus.occupancy, bus.full}, {1'b0, 3'd0, 1'b0});
    @(negedge clk);
    rst_b = 1'b0;
    bus.free_out = 1'b1;
    put_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (bus.put_out) put_seen = 1'b1;
    end
    chk("abort_no_bytes_after", {put_seen, bus.occupancy}, {1'b0, 3'd0});

    // Backpressure: ch1 offers five packets while the node is not free.
    bus.free_out = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.req_valid = 4'b0010;
      bus.req_pkt[63:32] = t4_pkt(k);
      #1;
      chk($sformatf("bp_grant%0d", k), {bus.req_ready, bus.full},
          (k < 4) ? {4'b0010, 1'b0} : {4'b0000, 1'b1});
    end
    chk("bp_full", {bus.occupancy, bus.full}, {3'd4, 1'b1});

    accepted5 = 1'b0;
    bytes_q.delete();
    for (int c = 0; c < 100 && bytes_q.size() < 20; c++) begin
      @(negedge clk);
      bus.free_out  = 1'b1;
      bus.req_valid = accepted5 ? 4'b0000 : 4'b0010;
      #1;
      if (bus.req_valid[1] && bus.req_ready[1]) accepted5 = 1'b1;
      if (bus.put_out) bytes_q.push_back(bus.payload_out);
    end
    chk("bp_fifth_accepted", {31'd0, accepted5}, 32'd1);
    chk("bp_byte_count", bytes_q.size(), 32'd20);
    if (bytes_q.size() == 20) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("bp_pkt%0d", k),
            {bytes_q[4*k], bytes_q[4*k+1], bytes_q[4*k+2], bytes_q[4*k+3]}, t4_pkt(k));
      end
    end
    @(negedge clk);
    #1;
    chk("bp_drained", {bus.put_out, bus.occupancy, bus.full}, {1'b0, 3'd0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
